// File: rtl/digest_serializer_if.sv
// Output word stream of the digest serializer: valid/ready handshake carrying
// one WORD_W-bit word, its byte-valid mask and an end-of-digest marker.
interface digest_serializer_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0]   dout;
  logic [WORD_W/8-1:0] dout_keep;
  logic                dout_valid;
  logic                dout_ready;
  logic                dout_last;

  modport master (
    output dout,
    output dout_keep,
    output dout_valid,
    output dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_keep,
    input  dout_valid,
    input  dout_last,
    output dout_ready
  );
endinterface

// File: rtl/digest_serializer.sv
// Captures a truncated SHAKE256 digest and streams its first L bits as
// little-endian WORD_W-bit words. Optional sticky overrun flag: SER_OVERRUN_FLAG_EN.
module digest_serializer #(
  parameter int MAX_L  = 512,
  parameter int WORD_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_truncate_done,
  input  logic [MAX_L-1:0]    i_y,
  input  logic [LEN_W-1:0]    i_out_len,
  digest_serializer_if.master m_out,
  output logic                o_busy,
  output logic                o_ser_done,
  output logic                o_overrun
);

  localparam int NW_MAX = MAX_L / WORD_W;
  localparam int IDX_W  = $clog2(NW_MAX) + 1;
  localparam int KEEP_W = WORD_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  function automatic logic [MAX_L-1:0] len_mask(input logic [LEN_W-1:0] lc);
    logic [MAX_L-1:0] m;
    for (int i = 0; i < MAX_L; i++) begin
      m[i] = (i < int'(lc));
    end
    return m;
  endfunction

  function automatic logic [KEEP_W-1:0] keep_of(input logic [LEN_W-1:0] rem);
    logic [KEEP_W-1:0] k;
    int                nbytes;
    nbytes = (int'(rem) + 7) / 8;
    for (int j = 0; j < KEEP_W; j++) begin
      k[j] = (j < nbytes);
    end
    return k;
  endfunction

  state_t             r_state;
  logic [MAX_L-1:0]   r_shift;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_lastidx;
  logic [KEEP_W-1:0]  r_last_keep;
  logic [WORD_W-1:0]  r_dout;
  logic [KEEP_W-1:0]  r_keep;
  logic               r_valid;
  logic               r_last;
  logic               r_busy;
  logic               r_ser_done;

  logic [LEN_W-1:0]   w_lc;
  logic [LEN_W-1:0]   w_rem;
  logic [IDX_W-1:0]   w_lastidx;
  logic [KEEP_W-1:0]  w_last_keep;
  logic [MAX_L-1:0]   w_ymask;
  logic [MAX_L-1:0]   w_shift_nx;
  logic [IDX_W-1:0]   w_idx_nx;
  logic               w_xfer;

  // Length clamp and last-word geometry; only meaningful when w_lc > 0.
  assign w_lc        = (i_out_len > LEN_W'(MAX_L)) ? LEN_W'(MAX_L) : i_out_len;
  assign w_rem       = ((w_lc - LEN_W'(1)) % LEN_W'(WORD_W)) + LEN_W'(1);
  assign w_lastidx   = IDX_W'((w_lc - LEN_W'(1)) / LEN_W'(WORD_W));
  assign w_last_keep = keep_of(w_rem);
  assign w_ymask     = i_y & len_mask(w_lc);

  assign w_shift_nx  = r_shift >> WORD_W;
  assign w_idx_nx    = r_idx + IDX_W'(1);
  assign w_xfer      = r_valid && m_out.dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_lastidx   <= '0;
      r_last_keep <= '0;
      r_dout      <= '0;
      r_keep      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_ser_done  <= 1'b0;
    end else begin
      r_ser_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_truncate_done) begin
            r_shift     <= w_ymask;
            r_idx       <= '0;
            r_lastidx   <= w_lastidx;
            r_last_keep <= w_last_keep;
            if (w_lc == '0) begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_ser_done <= 1'b1;
            end else begin
              r_state <= S_SEND;
              r_busy  <= 1'b1;
              r_valid <= 1'b1;
              r_dout  <= w_ymask[WORD_W-1:0];
              r_last  <= (w_lastidx == '0);
              r_keep  <= (w_lastidx == '0) ? w_last_keep : '1;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_SEND: begin
          // Index stops at the last word, so it can never wrap.
          if (w_xfer) begin
            if (r_last) begin
              r_state    <= S_DONE;
              r_valid    <= 1'b0;
              r_last     <= 1'b0;
              r_keep     <= '0;
              r_dout     <= '0;
              r_busy     <= 1'b0;
              r_ser_done <= 1'b1;
            end else begin
              r_idx   <= w_idx_nx;
              r_shift <= w_shift_nx;
              r_dout  <= w_shift_nx[WORD_W-1:0];
              r_last  <= (w_idx_nx == r_lastidx);
              r_keep  <= (w_idx_nx == r_lastidx) ? r_last_keep : '1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SER_OVERRUN_FLAG_EN
  logic r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (r_state == S_SEND && i_truncate_done) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 1'b0;
`endif

  assign m_out.dout       = r_dout;
  assign m_out.dout_keep  = r_keep;
  assign m_out.dout_valid = r_valid;
  assign m_out.dout_last  = r_last;
  assign o_busy           = r_busy;
  assign o_ser_done       = r_ser_done;

endmodule

// File: tb/tb_digest_serializer.sv
// Randomized and directed bench for digest_serializer; expected words come
// from a bit-level model of the truncation/packing rules.
module tb_digest_serializer;

  localparam int MAX_L  = 512;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 10;
  localparam int KEEP_W = WORD_W / 8;

  logic              clk;
  logic              rst;
  logic              tdone;
  logic [MAX_L-1:0]  ydat;
  logic [LEN_W-1:0]  olen;
  logic              busy;
  logic              ser_done;
  logic              overrun;

  int tests;
  int fails;

  digest_serializer_if #(.WORD_W(WORD_W)) bus ();

  digest_serializer #(
    .MAX_L (MAX_L),
    .WORD_W(WORD_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .i_truncate_done(tdone),
    .i_y            (ydat),
    .i_out_len      (olen),
    .m_out          (bus),
    .o_busy         (busy),
    .o_ser_done     (ser_done),
    .o_overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] exp_word(input logic [MAX_L-1:0] y, input int lc, input int k);
    logic [WORD_W-1:0] w;
    for (int b = 0; b < WORD_W; b++) begin
      w[b] = ((k * WORD_W + b) < lc) ? y[k * WORD_W + b] : 1'b0;
    end
    return w;
  endfunction

  function automatic logic [KEEP_W-1:0] exp_keep(input int lc, input int k);
    int nw;
    int rem;
    int nbytes;
    nw = (lc + WORD_W - 1) / WORD_W;
    if (k != nw - 1) return '1;
    rem    = lc - WORD_W * (nw - 1);
    nbytes = (rem + 7) / 8;
    return KEEP_W'((1 << nbytes) - 1);
  endfunction

  function automatic logic [MAX_L-1:0] rand_y();
    logic [MAX_L-1:0] y;
    for (int i = 0; i < MAX_L / 32; i++) y[i*32 +: 32] = $urandom;
    return y;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_dout"},  64'(bus.dout), 64'd0);
    chk({tag, "_keep"},  64'(bus.dout_keep), 64'd0);
    chk({tag, "_valid"}, 64'(bus.dout_valid), 64'd0);
    chk({tag, "_last"},  64'(bus.dout_last), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(ser_done), 64'd0);
    chk({tag, "_ovr"},   64'(overrun), 64'd0);
  endtask

  // rmode: 0 ready always, 1 ready toggling, 2 ready random.
  // inject_at: SEND cycle in which a second truncate_done is pulsed (-1 none).
  // abort_after: reset asserted once this word index has transferred (-1 none).
  task automatic run_digest(input logic [MAX_L-1:0] y, input int len, input int rmode,
                            input int inject_at, input int abort_after);
    int   lc;
    int   nw;
    int   k;
    int   cyc;
    logic rdy;
    lc = (len > MAX_L) ? MAX_L : len;
    nw = (lc + WORD_W - 1) / WORD_W;
    @(posedge clk); #1;
    tdone = 1'b1;
    ydat  = y;
    olen  = len[LEN_W-1:0];
    @(posedge clk); #1;
    tdone = 1'b0;
    ydat  = ~y;
    if (lc == 0) begin
      @(negedge clk);
      chk("l0_done", 64'(ser_done), 64'd1);
      chk("l0_valid", 64'(bus.dout_valid), 64'd0);
      chk("l0_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("l0_done_clr", 64'(ser_done), 64'd0);
      chk("l0_valid2", 64'(bus.dout_valid), 64'd0);
      return;
    end
    k   = 0;
    cyc = 0;
    while (k < nw && cyc < 400) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.dout_ready = rdy;
      if (cyc == inject_at) begin
        tdone = 1'b1;
        ydat  = rand_y();
        olen  = 10'd64;
      end else begin
        tdone = 1'b0;
      end
      @(negedge clk);
      chk("valid", 64'(bus.dout_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("dout", 64'(bus.dout), 64'(exp_word(y, lc, k)));
      chk("keep", 64'(bus.dout_keep), 64'(exp_keep(lc, k)));
      chk("last", 64'(bus.dout_last), 64'(k == nw - 1));
      chk("done_mid", 64'(ser_done), 64'd0);
      @(posedge clk); #1;
      if (rdy) k++;
      cyc++;
      if (abort_after >= 0 && k == abort_after + 1) begin
        tdone = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_zero("abort");
        rst = 1'b0;
        bus.dout_ready = 1'b0;
        return;
      end
    end
    tdone = 1'b0;
    bus.dout_ready = 1'b0;
    chk("word_count", 64'(k), 64'(nw));
    @(negedge clk);
    chk("end_done", 64'(ser_done), 64'd1);
    chk("end_valid", 64'(bus.dout_valid), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("end_done_clr", 64'(ser_done), 64'd0);
    chk("end_valid2", 64'(bus.dout_valid), 64'd0);
  endtask

  initial begin
    logic [MAX_L-1:0] yb;
    logic [MAX_L-1:0] ones;
    logic             ovr_exp;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    tdone = 1'b0;
    ydat  = '0;
    olen  = '0;
    bus.dout_ready = 1'b0;
`ifdef SER_OVERRUN_FLAG_EN
    ovr_exp = 1'b1;
`else
    ovr_exp = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < MAX_L / 8; i++) yb[i*8 +: 8] = 8'(i);
    ones = '1;

    // Byte-ramp digest, full length, ready held high.
    run_digest(yb, 512, 0, -1, -1);
    // Short length: single partial word.
    run_digest(ones, 20, 0, -1, -1);
    // Backpressure alternating every cycle.
    run_digest(rand_y(), 256, 1, -1, -1);
    // Zero length and over-long length.
    run_digest(rand_y(), 0, 0, -1, -1);
    run_digest(rand_y(), 600, 0, -1, -1);
    // Capture attempt during SEND must be ignored.
    chk("ovr_before", 64'(overrun), 64'd0);
    run_digest(yb, 512, 2, 3, -1);
    chk("ovr_after", 64'(overrun), 64'(ovr_exp));
    run_digest(rand_y(), 100, 0, -1, -1);
    chk("ovr_sticky", 64'(overrun), 64'(ovr_exp));
    // Reset after word 3, then a fresh digest restarts from word 0.
    run_digest(rand_y(), 512, 0, -1, 3);
    run_digest(yb, 72, 0, -1, -1);
    // Randomized lengths and backpressure.
    for (int n = 0; n < 12; n++) begin
      run_digest(rand_y(), int'($urandom_range(0, 600)), 2, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
